// File: rtl/da_pkg.sv
// Shared state type, width helper and frame-size guard
// for the multi-channel serial DAC driver.
`ifndef DA_PKG_SV
`define DA_PKG_SV

`define DA_CHECK_FRAME(FL, AW, DW) \
   if ((FL) < (AW) + (DW)) begin : g_frame_too_short \
      $error("FRAME_LEN too short for address plus data"); \
   end

package da_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } da_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/da_sclk_gen.sv
// SCLK phase generator: CLK_DIV clocks per half period,
// parked high with the counter cleared while disabled.
module da_sclk_gen
   import da_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clock,
   input  logic nRESET,
   input  logic en,
   output logic tick,
   output logic sclk_hi
);

   localparam int CNT_W = (clog2(CLK_DIV) > 0) ? clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;
   logic             phase;

   assign tick    = en && (cnt == CNT_W'(CLK_DIV - 1));
   assign sclk_hi = phase;

   always_ff @(posedge clock or negedge nRESET) begin
      if (!nRESET) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/da_serial_multi.sv
// Multi-channel serial DAC driver (nSYNC/SCLK/DIN, MSB-first).
// Define DA_SKIP_UNCHANGED_EN to skip channels whose level is unchanged.
module da_serial_multi
   import da_pkg::*;
#(
   parameter int CH_NUM    = 4,
   parameter int DATA_W    = 8,
   parameter int FRAME_LEN = 16,
   parameter int CLK_DIV   = 2
) (
   input  logic                     clock,
   input  logic                     nRESET,
   input  logic [CH_NUM*DATA_W-1:0] level,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     nSYNC,
   output logic                     SCLK,
   output logic                     DIN
);

   localparam int ADDR_W = clog2(CH_NUM);
   localparam int CW     = (ADDR_W > 0) ? ADDR_W : 1;
   localparam int BW     = (clog2(FRAME_LEN) > 0) ? clog2(FRAME_LEN) : 1;
   localparam int GW     = (clog2(2 * CLK_DIV) > 0) ? clog2(2 * CLK_DIV) : 1;
   localparam int PAD    = FRAME_LEN - ADDR_W - DATA_W;

   `DA_CHECK_FRAME(FRAME_LEN, ADDR_W, DATA_W)

   da_state_e                 state, state_n;
   logic [CW-1:0]             ch;
   logic [BW-1:0]             bcnt;
   logic [GW-1:0]             gcnt;
   logic                      pending;
   logic [CH_NUM*DATA_W-1:0]  shadow;
   logic [FRAME_LEN-1:0]      sh;

   logic [CH_NUM*DATA_W-1:0]  src;
   int                        first;
   logic                      nxt_ok;
   logic [CW-1:0]             nxt_ch;
   logic [DATA_W-1:0]         nxt_data;
   logic                      ld;
   logic                      tick, sclk_hi;
   logic                      bit_end, last_bit, gap_end;

`ifdef DA_SKIP_UNCHANGED_EN
   logic [CH_NUM*DATA_W-1:0]  last_sent;
`endif

   function automatic logic [FRAME_LEN-1:0] frame_of(
      input logic [CW-1:0]     c,
      input logic [DATA_W-1:0] d
   );
      logic [FRAME_LEN-1:0] f;
      f = FRAME_LEN'(d) << PAD;
      if (ADDR_W > 0) f = f | (FRAME_LEN'(c) << (FRAME_LEN - ADDR_W));
      return f;
   endfunction

   da_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .clock   (clock),
      .nRESET  (nRESET),
      .en      (state == SHIFT),
      .tick    (tick),
      .sclk_hi (sclk_hi)
   );

   assign bit_end  = tick && !sclk_hi;
   assign last_bit = (bcnt == BW'(FRAME_LEN - 1));
   assign gap_end  = (gcnt == GW'(2 * CLK_DIV - 1));

   // In LOAD the shadow is not yet valid, so look at the live bank.
   always_comb begin
      src    = (state == LOAD) ? level : shadow;
      first  = (state == LOAD) ? 0 : int'(ch) + 1;
      nxt_ok = 1'b0;
      nxt_ch = '0;
      for (int c = CH_NUM - 1; c >= 0; c--) begin
`ifdef DA_SKIP_UNCHANGED_EN
         if (c >= first &&
             src[c*DATA_W +: DATA_W] != last_sent[c*DATA_W +: DATA_W]) begin
`else
         if (c >= first) begin
`endif
            nxt_ok = 1'b1;
            nxt_ch = CW'(c);
         end
      end
   end

   assign nxt_data = src[int'(nxt_ch)*DATA_W +: DATA_W];

   always_comb begin
      state_n = state;
      done    = 1'b0;
      ld      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_n = LOAD;
         end
         LOAD: begin
            if (nxt_ok) begin
               ld      = 1'b1;
               state_n = SHIFT;
            end else begin
               done    = 1'b1;
               state_n = (pending || start) ? LOAD : IDLE;
            end
         end
         SHIFT: begin
            if (bit_end && last_bit) state_n = GAP;
         end
         GAP: begin
            if (gap_end) begin
               if (nxt_ok) begin
                  ld      = 1'b1;
                  state_n = SHIFT;
               end else begin
                  done    = 1'b1;
                  state_n = (pending || start) ? LOAD : IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nRESET) begin
      if (!nRESET) begin
         state   <= IDLE;
         ch      <= '0;
         bcnt    <= '0;
         gcnt    <= '0;
         pending <= 1'b0;
         shadow  <= '0;
         sh      <= '0;
      end else begin
         state <= state_n;
         if (state_n == LOAD) pending <= 1'b0;
         else if (start && state != IDLE) pending <= 1'b1;
         if (state == LOAD) shadow <= level;
         if (ld) begin
            ch   <= nxt_ch;
            sh   <= frame_of(nxt_ch, nxt_data);
            bcnt <= '0;
         end else if (state == SHIFT && bit_end) begin
            sh   <= sh << 1;
            bcnt <= bcnt + 1'b1;
         end
         if (state == GAP && !gap_end) gcnt <= gcnt + 1'b1;
         else gcnt <= '0;
      end
   end

`ifdef DA_SKIP_UNCHANGED_EN
   // All-ones start value forces a full first sweep.
   always_ff @(posedge clock or negedge nRESET) begin
      if (!nRESET) begin
         last_sent <= '1;
      end else if (state == SHIFT && bit_end && last_bit) begin
         last_sent[int'(ch)*DATA_W +: DATA_W] <=
            shadow[int'(ch)*DATA_W +: DATA_W];
      end
   end
`endif

   assign busy  = (state != IDLE);
   assign nSYNC = (state != SHIFT);
   assign SCLK  = (state != SHIFT) || sclk_hi;
   assign DIN   = (state == SHIFT) && sh[FRAME_LEN-1];

endmodule

// File: tb/tb_da_serial_multi.sv
// Directed bench for da_serial_multi (4 ch, 8 bit, 16-bit frame, div 2).
// Skip scenario runs only when DA_SKIP_UNCHANGED_EN is defined.
module tb_da_serial_multi;

   logic        clock  = 1'b0;
   logic        nRESET = 1'b1;
   logic [31:0] level  = '0;
   logic        start  = 1'b0;
   logic        busy, done, nSYNC, SCLK, DIN;

   int errors = 0;
   int checks = 0;

   da_serial_multi dut (
      .clock  (clock),
      .nRESET (nRESET),
      .level  (level),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .nSYNC  (nSYNC),
      .SCLK   (SCLK),
      .DIN    (DIN)
   );

   always #5 clock = ~clock;

   // line monitor, sampled on the falling system-clock edge
   logic [15:0] fr_bits[256];
   int          fr_falls[256];
   int          fr_n = 0;
   int          ns_falls = 0;
   int          glitches = 0;
   int          idle_edges = 0;
   int          done_cnt = 0;
   logic [15:0] cur_bits = '0;
   int          cur_falls = 0;
   logic        p_ns = 1'b1, p_sc = 1'b1, p_din = 1'b0;

   always @(negedge clock) begin
      if (!nSYNC && p_ns) begin
         cur_bits  = '0;
         cur_falls = 0;
         ns_falls++;
      end
      if (!nSYNC && !p_ns) begin
         if (!SCLK && p_sc) begin
            cur_falls++;
            cur_bits = {cur_bits[14:0], DIN};
         end
         if (DIN !== p_din && !(SCLK && !p_sc)) glitches++;
      end
      if (nSYNC && p_ns && SCLK !== p_sc) idle_edges++;
      if (nSYNC && !p_ns && fr_n < 256) begin
         fr_bits[fr_n]  = cur_bits;
         fr_falls[fr_n] = cur_falls;
         fr_n++;
      end
      if (done === 1'b1) done_cnt++;
      p_ns  = nSYNC;
      p_sc  = SCLK;
      p_din = DIN;
   end

   function automatic logic [15:0] exp_frame(input int c, input logic [7:0] d);
      logic [1:0] a;
      a = 2'(c);
      return {a, d, 6'b000000};
   endfunction

   task automatic pulse_start;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n, output int busy_lo);
      n = 1;
      busy_lo = 0;
      while (done !== 1'b1 && n < limit) begin
         if (busy !== 1'b1) busy_lo++;
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset;
      #1 nRESET = 1'b0;
      #3;
      checks++;
      if ({nSYNC, SCLK, DIN, busy, done} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_in got=%b want=11000", {nSYNC, SCLK, DIN, busy, done});
      end
      repeat (2) @(negedge clock);
      nRESET = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({nSYNC, SCLK, DIN, busy, done} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_out got=%b want=11000", {nSYNC, SCLK, DIN, busy, done});
      end
   endtask

   task automatic test_sweep;
      logic [7:0] lv[4];
      int n, bl, f0, d0, g0, i0;
      lv = '{8'h11, 8'h22, 8'h33, 8'hA5};
      level = {lv[3], lv[2], lv[1], lv[0]};
      f0 = fr_n; d0 = done_cnt; g0 = glitches; i0 = idle_edges;
      pulse_start();
      wait_done(400, n, bl);
      checks++;
      if (n != 273) begin
         errors++;
         $display("FAIL sweep_done_clock got=%0d want=273", n);
      end
      checks++;
      if (bl != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL sweep_busy low_cycles=%0d busy=%b want 0/1", bl, busy);
      end
      @(negedge clock);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL sweep_after got=%b want=00", {busy, done});
      end
      checks++;
      if (fr_n - f0 != 4 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL sweep_counts frames=%0d dones=%0d want 4/1", fr_n - f0, done_cnt - d0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fr_bits[f0+i] !== exp_frame(i, lv[i]) || fr_falls[f0+i] != 16) begin
            errors++;
            $display("FAIL sweep_frame%0d got=%h/%0d want=%h/16", i,
                     fr_bits[f0+i], fr_falls[f0+i], exp_frame(i, lv[i]));
         end
      end
      checks++;
      if (fr_bits[f0+3] !== 16'hE940) begin
         errors++;
         $display("FAIL sweep_frame3_lit got=%h want=e940", fr_bits[f0+3]);
      end
      checks++;
      if (glitches - g0 != 0 || idle_edges - i0 != 0) begin
         errors++;
         $display("FAIL sweep_sclk_din glitches=%0d idle_edges=%0d want 0/0",
                  glitches - g0, idle_edges - i0);
      end
   endtask

   task automatic test_snapshot;
      logic [7:0] la[4], lb[4];
      int n, bl, f0;
      la = '{8'h41, 8'h42, 8'h43, 8'h44};
      lb = '{8'h81, 8'h82, 8'h83, 8'h84};
      level = {la[3], la[2], la[1], la[0]};
      f0 = fr_n;
      pulse_start();
      n = 1;
      while (done !== 1'b1 && n < 400) begin
         if (n == 5) level = {lb[3], lb[2], lb[1], lb[0]};
         @(negedge clock);
         n++;
      end
      checks++;
      if (n != 273) begin
         errors++;
         $display("FAIL snap_done_clock got=%0d want=273", n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fr_bits[f0+i] !== exp_frame(i, la[i])) begin
            errors++;
            $display("FAIL snap_old%0d got=%h want=%h", i, fr_bits[f0+i], exp_frame(i, la[i]));
         end
      end
      @(negedge clock);
      f0 = fr_n;
      pulse_start();
      wait_done(400, n, bl);
      checks++;
      if (n != 273 || fr_n - f0 != 4) begin
         errors++;
         $display("FAIL snap2_timing clock=%0d frames=%0d want 273/4", n, fr_n - f0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fr_bits[f0+i] !== exp_frame(i, lb[i])) begin
            errors++;
            $display("FAIL snap_new%0d got=%h want=%h", i, fr_bits[f0+i], exp_frame(i, lb[i]));
         end
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      logic [7:0] lc[4], ld[4];
      int n, bl, f0, d0;
      lc = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      ld = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      level = {lc[3], lc[2], lc[1], lc[0]};
      f0 = fr_n; d0 = done_cnt;
      pulse_start();
      n = 1;
      while (done !== 1'b1 && n < 400) begin
         if (n == 10 || n == 50 || n == 200) start = 1'b1;
         else start = 1'b0;
         if (n == 10) level = {ld[3], ld[2], ld[1], ld[0]};
         @(negedge clock);
         n++;
      end
      start = 1'b0;
      checks++;
      if (n != 273) begin
         errors++;
         $display("FAIL b2b_first_done got=%0d want=273", n);
      end
      @(negedge clock);
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_reload got=%b want=10", {busy, done});
      end
      wait_done(400, n, bl);
      checks++;
      if (n != 273 || bl != 0) begin
         errors++;
         $display("FAIL b2b_second_done clock=%0d busy_low=%0d want 273/0", n, bl);
      end
      repeat (300) @(negedge clock);
      checks++;
      if (done_cnt - d0 != 2 || fr_n - f0 != 8 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_counts dones=%0d frames=%0d busy=%b want 2/8/0",
                  done_cnt - d0, fr_n - f0, busy);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fr_bits[f0+i] !== exp_frame(i, lc[i]) ||
             fr_bits[f0+4+i] !== exp_frame(i, ld[i])) begin
            errors++;
            $display("FAIL b2b_frame%0d got=%h,%h want=%h,%h", i, fr_bits[f0+i],
                     fr_bits[f0+4+i], exp_frame(i, lc[i]), exp_frame(i, ld[i]));
         end
      end
   endtask

   task automatic test_mid_reset;
      int n, s0, d0;
      level = {8'h00, 8'h00, 8'h26, 8'h00};
      pulse_start();
      n = 1;
      while (n < 100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if ({nSYNC, SCLK, DIN} !== 3'b001) begin
         errors++;
         $display("FAIL midrst_before got=%b want=001", {nSYNC, SCLK, DIN});
      end
      #2 nRESET = 1'b0;
      #1;
      checks++;
      if ({nSYNC, SCLK, DIN, busy, done} !== 5'b11000) begin
         errors++;
         $display("FAIL midrst_instant got=%b want=11000", {nSYNC, SCLK, DIN, busy, done});
      end
      @(negedge clock);
      #2 nRESET = 1'b1;
      s0 = ns_falls; d0 = done_cnt;
      repeat (300) @(negedge clock);
      checks++;
      if (ns_falls - s0 != 0 || done_cnt - d0 != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after syncs=%0d dones=%0d busy=%b want 0/0/0",
                  ns_falls - s0, done_cnt - d0, busy);
      end
   endtask

`ifdef DA_SKIP_UNCHANGED_EN
   task automatic test_skip;
      int n, bl, f0, s0;
      level = {8'hA5, 8'h33, 8'h22, 8'h11};
      f0 = fr_n;
      pulse_start();
      wait_done(400, n, bl);
      checks++;
      if (n != 273 || fr_n - f0 != 4) begin
         errors++;
         $display("FAIL skip_first clock=%0d frames=%0d want 273/4", n, fr_n - f0);
      end
      @(negedge clock);
      level = {8'hA5, 8'h5A, 8'h22, 8'h11};
      f0 = fr_n;
      pulse_start();
      wait_done(400, n, bl);
      checks++;
      if (n != 69 || fr_n - f0 != 1 || fr_bits[f0] !== 16'h9680) begin
         errors++;
         $display("FAIL skip_one clock=%0d frames=%0d frame=%h want 69/1/9680",
                  n, fr_n - f0, fr_bits[f0]);
      end
      @(negedge clock);
      s0 = ns_falls;
      pulse_start();
      wait_done(20, n, bl);
      checks++;
      if (n > 2 || ns_falls - s0 != 0) begin
         errors++;
         $display("FAIL skip_none clock=%0d syncs=%0d want <=2/0", n, ns_falls - s0);
      end
      repeat (5) @(negedge clock);
   endtask
`endif

   initial begin
      test_reset();
      test_sweep();
      test_snapshot();
      test_back_to_back();
      test_mid_reset();
`ifdef DA_SKIP_UNCHANGED_EN
      test_skip();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
